// File: rtl/mux_arb.sv
// mux_arb: NUM-way selector (external select or round-robin) feeding one
// registered valid/ready output stage that absorbs consumer backpressure.
module mux_arb #(
    parameter  int WIDTH = 32,
    parameter  int NUM   = 4,
    localparam int SEL_W = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM-1:0]       src_valid,
    input  logic [NUM*WIDTH-1:0] src_data,
    output logic [NUM-1:0]       src_ready,
    output logic                 res_valid,
    output logic [WIDTH-1:0]     res_data,
    output logic [SEL_W-1:0]     res_sel,
    input  logic                 res_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_gnt_data;
    int               w_dist;
    int               w_best;

    assign w_load_en = !r_valid || res_ready;

    // Round-robin picks the requester closest to r_ptr going upward modulo NUM,
    // so non-power-of-two channel counts never alias onto a missing index.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_dist    = 0;
        w_best    = NUM;
        if (!mode) begin
            for (int i = 0; i < NUM; i++) begin
                if (sel == SEL_W'(i) && src_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + NUM - int'(r_ptr));
                if (src_valid[i] && (w_dist < w_best)) begin
                    w_best    = w_dist;
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        src_ready  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_gnt_data = src_data[i*WIDTH +: WIDTH];
            end
            src_ready[i] = rstn && w_load_en && w_gnt_vld && (w_gnt_idx == SEL_W'(i));
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NUM-1)) ? '0 : (w_gnt_idx + SEL_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            r_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_data <= w_gnt_data;
                r_sel  <= w_gnt_idx;
                if (mode) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign res_valid = r_valid;
    assign res_data  = r_data;
    assign res_sel   = r_sel;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a 4x32 instance and a 3x8 instance driven by
// directed then random stimulus, checked against a queue-based reference model.
module tb_mux_arb;

    logic         clk = 1'b0;
    logic         rstn;

    logic         a_mode, a_res_ready, a_res_valid;
    logic [1:0]   a_sel, a_res_sel;
    logic [3:0]   a_valid, a_src_ready;
    logic [127:0] a_data;
    logic [31:0]  a_res_data;

    logic         b_mode, b_res_ready, b_res_valid;
    logic [1:0]   b_sel, b_res_sel;
    logic [2:0]   b_valid, b_src_ready;
    logic [23:0]  b_data;
    logic [7:0]   b_res_data;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } item_t;

    item_t q_a[$];
    item_t q_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    // model state: does the output register hold data, and the RR pointer
    bit va, vb;
    int pa, pb;

    always #5 clk = ~clk;

    mux_arb #(.WIDTH(32), .NUM(4)) u_a (
        .clk(clk), .rstn(rstn), .mode(a_mode), .sel(a_sel),
        .src_valid(a_valid), .src_data(a_data), .src_ready(a_src_ready),
        .res_valid(a_res_valid), .res_data(a_res_data), .res_sel(a_res_sel),
        .res_ready(a_res_ready)
    );

    mux_arb #(.WIDTH(8), .NUM(3)) u_b (
        .clk(clk), .rstn(rstn), .mode(b_mode), .sel(b_sel),
        .src_valid(b_valid), .src_data(b_data), .src_ready(b_src_ready),
        .res_valid(b_res_valid), .res_data(b_res_data), .res_sel(b_res_sel),
        .res_ready(b_res_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Grant from the rules: fixed -> sel if in range and requesting;
    // RR -> first requester scanning ptr, ptr+1, ... modulo num.
    function automatic int model_grant(input int num, input bit m, input int s,
                                       input int v, input int ptr);
        if (!m) return (s < num && ((v >> s) & 1) != 0) ? s : -1;
        for (int k = 0; k < num; k++) begin
            int c;
            c = (ptr + k) % num;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    // One clock: drive one DUT (the other idles and drains), check src_ready,
    // predict the edge, then check res_valid after the edge.
    task automatic step(input int which, input bit m, input int s, input int v, input bit rdy);
        logic [31:0] dv [4];
        int          num, g, ptr, exp_rdy, act_rdy;
        bit          mv, load_en;
        item_t       it;
        for (int i = 0; i < 4; i++) dv[i] = $urandom;
        if (which == 0) begin
            num = 4; mv = va; ptr = pa;
            a_mode = m; a_sel = s[1:0]; a_valid = v[3:0]; a_res_ready = rdy;
            for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = dv[i];
            b_valid = '0; b_res_ready = 1'b1;
        end else begin
            num = 3; mv = vb; ptr = pb;
            b_mode = m; b_sel = s[1:0]; b_valid = v[2:0]; b_res_ready = rdy;
            for (int i = 0; i < 3; i++) begin
                dv[i] = {24'h0, dv[i][7:0]};
                b_data[i*8 +: 8] = dv[i][7:0];
            end
            a_valid = '0; a_res_ready = 1'b1;
        end
        load_en = !mv || rdy;
        g = model_grant(num, m, s, v, ptr);
        exp_rdy = (load_en && g >= 0) ? (1 << g) : 0;
        #1;
        act_rdy = (which == 0) ? int'(a_src_ready) : int'(b_src_ready);
        chk((which == 0) ? "a_src_ready" : "b_src_ready", 64'(act_rdy), 64'(exp_rdy));
        if (load_en) begin
            mv = (g >= 0);
            if (g >= 0) begin
                it.d = dv[g];
                it.s = 2'(g);
                if (which == 0) q_a.push_back(it); else q_b.push_back(it);
                if (m) ptr = (g + 1) % num;
            end
        end
        if (which == 0) begin va = mv; pa = ptr; vb = 1'b0; end
        else begin vb = mv; pb = ptr; va = 1'b0; end
        @(posedge clk);
        #1;
        chk("a_res_valid", 64'(a_res_valid), 64'(va));
        chk("b_res_valid", 64'(b_res_valid), 64'(vb));
    endtask

    // Monitor: while the register is full it must hold the oldest expected
    // item; the item leaves the scoreboard when the consumer takes it.
    always @(negedge clk) begin
        if (rstn) begin
            if (a_res_valid) begin
                if (q_a.size() == 0) chk("a_unexpected_item", 64'(a_res_valid), 64'(0));
                else begin
                    chk("a_res_data", 64'(a_res_data), 64'(q_a[0].d));
                    chk("a_res_sel", 64'(a_res_sel), 64'(q_a[0].s));
                    if (a_res_ready) void'(q_a.pop_front());
                end
            end
            if (b_res_valid) begin
                if (q_b.size() == 0) chk("b_unexpected_item", 64'(b_res_valid), 64'(0));
                else begin
                    chk("b_res_data", 64'({24'h0, b_res_data}), 64'(q_b[0].d));
                    chk("b_res_sel", 64'(b_res_sel), 64'(q_b[0].s));
                    if (b_res_ready) void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        a_mode = 1'b0; a_sel = '0; a_valid = '0; a_data = '0; a_res_ready = 1'b1;
        b_mode = 1'b0; b_sel = '0; b_valid = '0; b_data = '0; b_res_ready = 1'b1;
        va = 1'b0; vb = 1'b0; pa = 0; pb = 0;
        #3;
        chk("rst_a_res_valid", 64'(a_res_valid), 64'(0));
        chk("rst_a_res_data", 64'(a_res_data), 64'(0));
        chk("rst_a_src_ready", 64'(a_src_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // fixed mode: sel 2 granted, then sel 3 idle -> no grant, register empties
        step(0, 1'b0, 2, 4'b0110, 1'b1);
        step(0, 1'b0, 3, 4'b0111, 1'b1);
        step(0, 1'b0, 3, 4'b0111, 1'b1);

        // round-robin fairness with all requesting
        repeat (6) step(0, 1'b1, 0, 4'b1111, 1'b1);

        // backpressure: hold three cycles, then drain and reload on the same edge
        step(0, 1'b1, 0, 4'b1111, 1'b1);
        repeat (3) step(0, 1'b1, 0, 4'b1111, 1'b0);
        step(0, 1'b1, 0, 4'b0010, 1'b1);

        // mode switch: RR grant 1, two fixed transfers, RR resumes at 2
        step(0, 1'b1, 0, 4'b0010, 1'b1);
        repeat (2) step(0, 1'b0, 0, 4'b1111, 1'b1);
        step(0, 1'b1, 0, 4'b1111, 1'b1);

        // asynchronous reset mid-stream with data held
        step(0, 1'b1, 0, 4'b1111, 1'b1);
        a_valid = 4'b1111; a_res_ready = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("midrst_a_res_valid", 64'(a_res_valid), 64'(0));
        chk("midrst_a_res_data", 64'(a_res_data), 64'(0));
        chk("midrst_a_res_sel", 64'(a_res_sel), 64'(0));
        chk("midrst_a_src_ready", 64'(a_src_ready), 64'(0));
        q_a.delete(); q_b.delete();
        va = 1'b0; vb = 1'b0; pa = 0; pb = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        step(0, 1'b1, 0, 4'b1111, 1'b1);

        // three channels: RR over 3'b101, fixed sel 3 never grants
        repeat (4) step(1, 1'b1, 0, 3'b101, 1'b1);
        repeat (2) step(1, 1'b0, 3, 3'b111, 1'b1);
        repeat (3) step(1, 1'b1, 0, 3'b111, 1'b1);

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            int which;
            which = int'($urandom_range(0, 1));
            step(which, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        repeat (2) step(0, 1'b0, 0, 0, 1'b1);
        chk("a_queue_empty", 64'(q_a.size()), 64'(0));
        chk("b_queue_empty", 64'(q_b.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-input selector with a registered, valid/ready-handshaked output. It generalises the team's combinational 4:1 result mux to NUM channels of WIDTH bits. Selection is either by an external select (fixed mode) or by an internal round-robin arbiter. It sits between multiple producers (ALU, load unit, CSR, multiplier) and a single writeback consumer, and absorbs backpressure with one output register.

## Interface
- WIDTH, 32, data width per channel
- NUM, 4, channel count (≥2; need not be a power of two)
- SEL_W, $clog2(NUM), select/index width (derived, not overridden)

- clk  input  1  rising-edge clock
- rstn  input  1  reset, asynchronous, active-low
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- src_valid  input  NUM  per-channel request
- src_data  input  NUM*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- src_ready  output  NUM  per-channel accept; combinational
- res_valid  output  1  output register holds data
- res_data  output  WIDTH  registered selected data
- res_sel  output  SEL_W  index of the channel held in the output register
- res_ready  input  1  consumer accept

## Operation
- Decided: one clock (clk); reset rstn is asynchronous, active-low.
- load_en = !res_valid || res_ready. The output register accepts only when load_en = 1.
- Fixed mode (mode = 0):
  - grant = sel if sel < NUM and src_valid[sel] = 1; otherwise no grant.
  - The round-robin pointer is not modified.
- Round-robin mode (mode = 1):
  - Search channels ptr, ptr+1, … wrapping modulo NUM (not 2^SEL_W).
  - The first channel with src_valid = 1 is granted.
- src_ready[i] = load_en && grant valid && grant == i. At most one bit is set.
- Transfer from channel i happens when src_valid[i] && src_ready[i]. On that edge:
  - res_data ← src_data[i]
  - res_sel ← i
  - res_valid ← 1
  - in RR mode, ptr ← (i+1) mod NUM, so channel NUM-1 wraps to 0.
- Output drains when res_valid && res_ready. If no new transfer happens on the same edge, res_valid ← 0.
- Simultaneous drain and load: res_ready = 1 with a granted request replaces the register the same cycle. Throughput is 1 per clock, with no bubble.
- While res_valid && !res_ready:
  - all src_ready = 0;
  - res_data and res_sel are held stable;
  - ptr is held.
- A mode or sel change takes effect on the next arbitration evaluation (combinational). It never alters data already in the register.
- No grant: register unchanged except for the drain rule above.
- Reset, including mid-transfer: asynchronously res_valid = 0, res_data = 0, res_sel = 0, ptr = 0. src_ready goes to 0 because no request is evaluated until reset is released. Any in-flight datum is discarded.

## Timing
- Latency: 1 clock from accepted source handshake to res_valid = 1.
- src_ready has a combinational path from src_valid, sel, mode and res_ready. src_valid must not depend on src_ready.
- res_data, res_valid and res_sel are pure register outputs.
- Sustained rate is one item per cycle while res_ready = 1.
- In RR mode with all channels requesting continuously, each channel is granted exactly once per NUM consecutive transfers.

## Test plan
- Reset:
  - Stimulus: assert rstn = 0 mid-stream with res_valid = 1.
  - Response: res_valid/res_data/res_sel drop to 0 immediately, without waiting for a clock edge.
  - After release, with mode = 1 and all valid, the first grant is channel 0.
- Fixed mode, NUM = 4:
  - Stimulus: sel = 2, src_valid = 4'b0110, src_data[2] = 0xCAFE0002, res_ready = 1.
  - Response: src_ready = 4'b0100; next cycle res_data = 0xCAFE0002, res_sel = 2.
  - Then sel = 3 with src_valid[3] = 0: no grant, and res_valid falls to 0.
- Round-robin fairness:
  - Stimulus: all 4 valid continuously, res_ready = 1.
  - Response: res_sel sequence 0,1,2,3,0,1 on consecutive cycles, with res_valid held at 1.
- Backpressure:
  - Stimulus: res_ready = 0 for 3 cycles while res_data = 0x11.
  - Response: src_ready = 0, and res_data/res_sel stay constant.
  - Raise res_ready with channel 1 valid: the same edge drains 0x11 and loads channel 1, so res_valid never drops.
- Non-power-of-two: NUM = 3, WIDTH = 8.
  - RR with valid = 3'b101 gives grants 0,2,0,2, and ptr wraps from 2 to 0 (no index 3).
  - Fixed mode with sel = 3 never grants.
- Mode switch:
  - Stimulus: after RR grant 1 (ptr = 2), switch to mode = 0, sel = 0 for 2 transfers, then back to mode = 1 with all valid.
  - Response: the next RR grant is 2, showing ptr was preserved through fixed mode.
